// File: rtl/serial_bit_feeder.sv
// serial_bit_feeder: turns WIDTH-bit words into a one-bit-per-clock stream
// for a downstream sequence detector. Words arrive over a valid/ready handshake.
// A one-word holding buffer lets consecutive words stream with no idle bit between them.
// Bit order is selected by the macro SERIAL_FEEDER_LSB_FIRST_EN:
// defined means LSB first, undefined means MSB first.
module serial_bit_feeder #(
   parameter int unsigned WIDTH    = 8,
   parameter logic        IDLE_BIT = 1'b0
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic [WIDTH-1:0] din,
   input  logic             load,
   output logic             ready,
   output logic             x,
   output logic             x_valid,
   output logic             last,
   output logic             busy
);

   localparam int unsigned    CW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0]  CNT_TOP = CW'(WIDTH - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } stateT;

   stateT            state, stateNext;
   logic [WIDTH-1:0] shiftReg, shiftNext;
   logic [CW-1:0]    cnt, cntNext;
   logic [WIDTH-1:0] holdBuf, holdNext;
   logic             holdFull, holdFullNext;
   logic             accept;

   // The bit that appears on x is always the head end of the shift register.
   function automatic logic headBit(input logic [WIDTH-1:0] w);
`ifdef SERIAL_FEEDER_LSB_FIRST_EN
      return w[0];
`else
      return w[WIDTH-1];
`endif
   endfunction

   // Advance the shift register so the next bit lands at the head end.
   function automatic logic [WIDTH-1:0] shiftOn(input logic [WIDTH-1:0] w);
`ifdef SERIAL_FEEDER_LSB_FIRST_EN
      return {1'b0, w[WIDTH-1:1]};
`else
      return {w[WIDTH-2:0], 1'b0};
`endif
   endfunction

   // Next-state logic: word start, bit stepping, holding-buffer fill and drain.
   always_comb begin
      accept       = load && ready;
      stateNext    = state;
      shiftNext    = shiftReg;
      cntNext      = cnt;
      holdNext     = holdBuf;
      holdFullNext = holdFull;
      case (state)
         IDLE: begin
            if (accept) begin
               shiftNext = din;
               cntNext   = CNT_TOP;
               stateNext = SHIFT;
            end
         end
         SHIFT: begin
            if (cnt == '0) begin
               if (holdFull) begin
                  shiftNext    = holdBuf;
                  cntNext      = CNT_TOP;
                  holdFullNext = 1'b0;
               end else if (accept) begin
                  shiftNext = din;
                  cntNext   = CNT_TOP;
               end else begin
                  shiftNext = '0;
                  stateNext = IDLE;
               end
            end else begin
               shiftNext = shiftOn(shiftReg);
               cntNext   = cnt - CW'(1);
               if (accept) begin
                  holdNext     = din;
                  holdFullNext = 1'b1;
               end
            end
         end
         default: begin
            stateNext = IDLE;
         end
      endcase
   end

   // State and datapath registers; the outputs are registered from next-state values.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state    <= IDLE;
         shiftReg <= '0;
         cnt      <= '0;
         holdBuf  <= '0;
         holdFull <= 1'b0;
         ready    <= 1'b1;
         x        <= IDLE_BIT;
         x_valid  <= 1'b0;
         last     <= 1'b0;
         busy     <= 1'b0;
      end else begin
         state    <= stateNext;
         shiftReg <= shiftNext;
         cnt      <= cntNext;
         holdBuf  <= holdNext;
         holdFull <= holdFullNext;
         ready    <= ~holdFullNext;
         x        <= (stateNext == SHIFT) ? headBit(shiftNext) : IDLE_BIT;
         x_valid  <= (stateNext == SHIFT);
         last     <= (stateNext == SHIFT) && (cntNext == '0);
         busy     <= (stateNext == SHIFT) || holdFullNext;
      end
   end

endmodule

// File: doc/serial_bit_feeder.md
# serial_bit_feeder

Parallel-to-serial feeder that turns WIDTH-bit words into a one-bit-per-clock stream `x` for the downstream sequence-detector FSM, which samples its `x` input on every `CLK` edge. It accepts words through a valid/ready handshake. A one-word holding buffer lets consecutive words stream with no idle bit between them. When no word is being shifted, it drives a fixed idle level.

## Interface
- `WIDTH`, 8: word width in bits; legal range 2..32.
- `IDLE_BIT`, 0: value driven on `x` when no word is being shifted.

- `CLK`  in  1  clock; all flops on the rising edge.
- `RESET`  in  1  asynchronous, active-low reset.
- `din`  in  WIDTH  word to serialize.
- `load`  in  1  word-valid strobe from upstream.
- `ready`  out  1  holding buffer has room; a word is accepted when `load && ready` at a rising edge.
- `x`  out  1  serial bit to the detector (registered).
- `x_valid`  out  1  `x` carries a data bit this cycle.
- `last`  out  1  `x` is the final bit of the current word.
- `busy`  out  1  shifter active or holding buffer occupied.

## Operation
- Reset (async assert, `RESET`=0):
  - State IDLE; shift register, bit counter and holding buffer cleared.
  - Outputs: `x`=IDLE_BIT, `x_valid`=0, `last`=0, `busy`=0, `ready`=1.
  - A word in flight is discarded; no partial bits are emitted after reset deasserts.
- State IDLE:
  - Accepted word goes straight into the shift register; next state SHIFT.
  - `x`=IDLE_BIT, `x_valid`=0.
- State SHIFT:
  - One bit per cycle on `x`; bit counter runs WIDTH-1 down to 0.
  - `last`=1 when the counter is 0.
- Word accepted while in SHIFT: written to the holding buffer; `ready` drops to 0.
- Last-bit cycle (counter 0), in priority order:
  - Holding buffer full: buffer moves to the shift register, buffer empties, stay in SHIFT.
  - Else, word accepted this cycle: load it directly into the shift register (bypass), stay in SHIFT.
  - Else: go to IDLE.
- `ready` = NOT holding-buffer-full. It is registered, so it rises the cycle after the buffer drains.
- Holding buffer full and another `load` asserted: `ready`=0, word not accepted, upstream must hold it.
- `busy` = (state==SHIFT) OR holding-buffer-full.
- Bit order within a word is set by the configuration macro (see Configuration).
- Counter width is clog2(WIDTH); the counter reloads to WIDTH-1 on every word start and never wraps below 0.

## Timing
- Latency: word accepted at edge N (IDLE) → first bit on `x` with `x_valid`=1 during cycle N+1; last bit during cycle N+WIDTH.
- Back-to-back: a word accepted any time before the last-bit edge produces its first bit in the cycle immediately after the previous word's last bit. Zero gap.
- Sustained throughput is one word per WIDTH cycles. `ready` is 1 for exactly one cycle per word when upstream always has data.
- All outputs are registered; no combinational path from `load`/`din` to `x`.
- `RESET` deassertion is synchronized externally; the block requires only that it is glitch-free.

## Configuration
- `SERIAL_FEEDER_LSB_FIRST_EN`
  - Defined: `din[0]` is emitted first, `din[WIDTH-1]` last.
  - Not defined (default): MSB-first, `din[WIDTH-1]` first, `din[0]` last.
  - Handshake, latency and `last` timing are identical in both builds.

## Test plan
- Reset values: hold `RESET`=0 for 3 cycles → `x`=0, `x_valid`=0, `last`=0, `busy`=0, `ready`=1.
- Single word, MSB-first: WIDTH=8, load 8'hB4 at edge N → `x`=1,0,1,1,0,1,0,0 in cycles N+1..N+8; `last`=1 only in N+8; `x_valid`=0 and `x`=0 at N+9.
- Back-to-back: load 8'hFF, then 8'h00 two cycles later → 16 contiguous `x_valid` cycles (eight 1s then eight 0s); `ready`=0 from the cycle after 8'h00 is accepted until the cycle after its transfer.
- Backpressure: holding buffer full, assert `load` with 8'h5A → not accepted (`ready`=0). Keep `load` high → 8'h5A accepted the cycle `ready` returns to 1 and emitted as 0,1,0,1,1,0,1,0 right after the pending word.
- Reset mid-word: assert `RESET` after 3 bits of 8'hB4 with 8'hFF pending → outputs return to reset values immediately; after release `x_valid` stays 0 until a new `load`.
- LSB-first build (`SERIAL_FEEDER_LSB_FIRST_EN` defined): load 8'hB4 → `x`=0,0,1,0,1,1,0,1; `last` in the 8th bit cycle.
